led_cmd_scheduler: RTL and testbench

//  Round-robin scheduler between four debounced button requesters (dec, inc, dim, bright).

---
 rtl/led_cmd_pkg.sv | 22 ++
 rtl/led_cmd_scheduler_if.sv | 13 +
 rtl/led_pwm_gen.sv | 33 +++
 rtl/led_cmd_scheduler.sv | 123 ++++++++++++
 tb/tb_led_cmd_scheduler.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_cmd_pkg.sv
// Shared types, limits and the PWM duty table for the LED command scheduler.
package led_cmd_pkg;

    typedef enum logic [1:0] {OP_DEC, OP_INC, OP_DIM, OP_BRIGHT} op_e;
    typedef enum logic {S_IDLE, S_EXEC} state_e;

    localparam logic signed [3:0] COUNT_MIN = -4'sd8;
    localparam logic signed [3:0] COUNT_MAX = 4'sd7;
    localparam logic [2:0]        LVL_MAX   = 3'd4;

    // PWM output is on while pwm_cnt is below this threshold
    function automatic logic [31:0] duty_thr(input logic [2:0] level, input logic [31:0] period);
        case (level)
            3'd0:    duty_thr = period / 32'd20;
            3'd1:    duty_thr = period / 32'd4;
            3'd2:    duty_thr = period / 32'd2;
            3'd3:    duty_thr = (period * 32'd3) / 32'd4;
            default: duty_thr = period;
        endcase
    endfunction

endpackage

// File: rtl/led_cmd_scheduler_if.sv
// Request/status bundle between the button debouncers, the scheduler and the LED pins.
interface led_cmd_scheduler_if;
    logic        [3:0] req;
    logic        [3:0] pend;
    logic        [3:0] grant;
    logic signed [3:0] count;
    logic        [2:0] level;
    logic              period_st;
    logic        [3:0] usr_led;

    modport master (output req, input pend, grant, count, level, period_st, usr_led);
    modport slave  (input req, output pend, grant, count, level, period_st, usr_led);
endinterface

// File: rtl/led_pwm_gen.sv
// PWM period timer and duty compare for the applied brightness level.
module led_pwm_gen
    import led_cmd_pkg::*;
#(
    parameter int PWM_PERIOD = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] level,
    output logic       pwm_on,
    output logic       period_st
);
    localparam int CNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

    logic [CNT_W-1:0] r_pwm_cnt;
    logic             w_last;

    assign w_last = (r_pwm_cnt == CNT_W'(PWM_PERIOD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt <= '0;
        end else if (w_last) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    assign pwm_on    = (32'(r_pwm_cnt) < duty_thr(level, 32'(PWM_PERIOD)));
    assign period_st = w_last;

endmodule

// File: rtl/led_cmd_scheduler.sv
// Round-robin command scheduler driving a saturating count and PWM-dimmed LEDs.
// Optional build macro AUTO_DIM_EN adds an idle timer that injects dim requests.
module led_cmd_scheduler
    import led_cmd_pkg::*;
#(
    parameter int PWM_PERIOD   = 1_000_000,
    parameter int IDLE_TIMEOUT = 100_000_000
) (
    input  logic               clk,
    input  logic               reset,
    led_cmd_scheduler_if.slave bus
);
    state_e            r_state, w_state_nxt;
    logic        [3:0] r_pend, r_grant, w_grant_nxt, w_set, w_clr;
    logic        [1:0] r_rr_ptr, r_gnt_idx, w_pick;
    logic signed [3:0] r_count;
    logic        [2:0] r_level_nxt, r_level;
    logic        [3:0] r_usr_led;
    logic              w_pwm_on, w_period_st, w_auto_dim;

    function automatic logic signed [3:0] sat_count(input logic signed [3:0] c, input op_e op);
        sat_count = c;
        if (op == OP_DEC && c != COUNT_MIN)      sat_count = c - 4'sd1;
        else if (op == OP_INC && c != COUNT_MAX) sat_count = c + 4'sd1;
    endfunction

    function automatic logic [2:0] sat_level(input logic [2:0] l, input op_e op);
        sat_level = l;
        if (op == OP_DIM && l != 3'd0)           sat_level = l - 3'd1;
        else if (op == OP_BRIGHT && l != LVL_MAX) sat_level = l + 3'd1;
    endfunction

    // Scan downwards so the nearest set bit at or after rr_ptr wins
    always_comb begin
        w_pick = r_rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (r_pend[r_rr_ptr + 2'(k)]) w_pick = r_rr_ptr + 2'(k);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = '0;
        case (r_state)
            S_IDLE: if (|r_pend) begin
                w_state_nxt = S_EXEC;
                w_grant_nxt = 4'b0001 << w_pick;
            end
            S_EXEC:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A new request wins over the clear so a colliding pulse is not lost
    assign w_clr = (r_state == S_EXEC) ? r_grant : 4'b0000;
    assign w_set = bus.req | {1'b0, w_auto_dim, 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_gnt_idx   <= '0;
            r_rr_ptr    <= '0;
            r_pend      <= '0;
            r_count     <= '0;
            r_level_nxt <= '0;
            r_level     <= '0;
            r_usr_led   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_pend  <= (r_pend & ~w_clr) | w_set;
            if (r_state == S_IDLE && |r_pend) r_gnt_idx <= w_pick;
            if (r_state == S_EXEC) begin
                r_count     <= sat_count(r_count, op_e'(r_gnt_idx));
                r_level_nxt <= sat_level(r_level_nxt, op_e'(r_gnt_idx));
                r_rr_ptr    <= r_gnt_idx + 2'd1;
            end
            if (w_period_st) r_level <= r_level_nxt;
            r_usr_led <= w_pwm_on ? unsigned'(r_count) : 4'b0000;
        end
    end

`ifdef AUTO_DIM_EN
    localparam int IT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    logic [IT_W-1:0] r_idle_cnt;
    logic            w_idle_hit;

    assign w_idle_hit = (r_idle_cnt == IT_W'(IDLE_TIMEOUT - 1));
    assign w_auto_dim = (r_grant == 4'b0000) && w_idle_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= '0;
        end else if (|r_grant || w_idle_hit) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^32'(IDLE_TIMEOUT);
    assign w_auto_dim       = 1'b0;
`endif

    led_pwm_gen #(.PWM_PERIOD(PWM_PERIOD)) u_pwm (
        .clk       (clk),
        .reset     (reset),
        .level     (r_level),
        .pwm_on    (w_pwm_on),
        .period_st (w_period_st)
    );

    assign bus.pend      = r_pend;
    assign bus.grant     = r_grant;
    assign bus.count     = r_count;
    assign bus.level     = r_level;
    assign bus.period_st = w_period_st;
    assign bus.usr_led   = r_usr_led;

endmodule

// File: tb/tb_led_cmd_scheduler.sv
// Bench for led_cmd_scheduler: vector table, corner sequences and random traffic vs a reference model.
module tb_led_cmd_scheduler;
    localparam int P = 100;

    logic clk = 1'b0;
    logic reset = 1'b1;

    led_cmd_scheduler_if io();

    led_cmd_scheduler #(.PWM_PERIOD(P), .IDLE_TIMEOUT(50)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (io)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [3:0] m_pend, m_grant, m_led;
    int         m_ptr, m_g, m_count, m_lvl_nxt, m_lvl, m_cnt;
    bit         m_busy;

    typedef struct {
        logic [3:0] req;
        logic [3:0] pend;
        logic [3:0] grant;
        int         count;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int thr(input int lvl);
        case (lvl)
            0:       return P / 20;
            1:       return P / 4;
            2:       return P / 2;
            3:       return (3 * P) / 4;
            default: return P;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = '0; m_grant = '0; m_led = '0;
        m_ptr = 0; m_g = 0; m_count = 0; m_lvl_nxt = 0; m_lvl = 0; m_cnt = 0;
        m_busy = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] rq);
        int old_cnt, old_lvl, old_count, old_lvl_nxt;
        old_cnt = m_cnt; old_lvl = m_lvl; old_count = m_count; old_lvl_nxt = m_lvl_nxt;
        m_led = (old_cnt < thr(old_lvl)) ? 4'(old_count) : 4'b0000;
        if (old_cnt == P - 1) m_lvl = old_lvl_nxt;
        m_cnt = (old_cnt + 1) % P;
        if (m_busy) begin
            case (m_g)
                0: if (m_count > -8) m_count = m_count - 1;
                1: if (m_count < 7) m_count = m_count + 1;
                2: if (m_lvl_nxt > 0) m_lvl_nxt = m_lvl_nxt - 1;
                default: if (m_lvl_nxt < 4) m_lvl_nxt = m_lvl_nxt + 1;
            endcase
            m_pend[m_g] = 1'b0;
            m_ptr   = (m_g + 1) % 4;
            m_grant = '0;
            m_busy  = 1'b0;
        end else if (m_pend != 4'b0000) begin
            for (int k = 3; k >= 0; k--) begin
                if (m_pend[(m_ptr + k) % 4]) m_g = (m_ptr + k) % 4;
            end
            m_grant = 4'(1 << m_g);
            m_busy  = 1'b1;
        end
        m_pend = m_pend | rq;
    endtask

    task automatic check_model();
        check("mdl_grant", int'(io.grant), int'(m_grant));
        check("mdl_pend", int'(io.pend), int'(m_pend));
        check("mdl_count", int'($signed(io.count)), m_count);
        check("mdl_level", int'(io.level), m_lvl);
        check("mdl_led", int'(io.usr_led), int'(m_led));
        check("mdl_period_st", int'(io.period_st), (m_cnt == P - 1) ? 1 : 0);
    endtask

    task automatic tick(input logic [3:0] rq);
        io.req = rq;
        @(posedge clk);
        model_step(rq);
        #1;
        io.req = 4'b0000;
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         nz, ng, guard;
        bit         bad;
        logic [3:0] seen[$];
        int         at[$];

        tbl[0]  = '{4'b0010, 4'b0010, 4'b0000, 0};
        tbl[1]  = '{4'b0000, 4'b0010, 4'b0010, 0};
        tbl[2]  = '{4'b0000, 4'b0000, 4'b0000, 1};
        tbl[3]  = '{4'b0001, 4'b0001, 4'b0000, 1};
        tbl[4]  = '{4'b0000, 4'b0001, 4'b0001, 1};
        tbl[5]  = '{4'b1111, 4'b1111, 4'b0000, 0};
        tbl[6]  = '{4'b0000, 4'b1111, 4'b0010, 0};
        tbl[7]  = '{4'b0000, 4'b1101, 4'b0000, 1};
        tbl[8]  = '{4'b0000, 4'b1101, 4'b0100, 1};
        tbl[9]  = '{4'b0000, 4'b1001, 4'b0000, 1};
        tbl[10] = '{4'b0000, 4'b1001, 4'b1000, 1};
        tbl[11] = '{4'b0000, 4'b0001, 4'b0000, 1};
        tbl[12] = '{4'b0000, 4'b0001, 4'b0001, 1};
        tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 0};

        io.req = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pend", int'(io.pend), 0);
        check("rst_grant", int'(io.grant), 0);
        check("rst_count", int'($signed(io.count)), 0);
        check("rst_level", int'(io.level), 0);
        check("rst_period_st", int'(io.period_st), 0);
        check("rst_led", int'(io.usr_led), 0);
        reset = 1'b0;

        // Vector table from reset
        foreach (tbl[i]) begin
            tick(tbl[i].req);
            check("tbl_pend", int'(io.pend), int'(tbl[i].pend));
            check("tbl_grant", int'(io.grant), int'(tbl[i].grant));
            check("tbl_count", int'($signed(io.count)), tbl[i].count);
        end

        // Round-robin order from all four requests in one cycle
        do_reset();
        tick(4'b1111);
        for (int c = 0; c < 8; c++) begin
            tick(4'b0000);
            if (io.grant != 4'b0000) begin
                seen.push_back(io.grant);
                at.push_back(c);
            end
        end
        check("rr_ngrants", seen.size(), 4);
        if (seen.size() == 4) begin
            check("rr_g0", int'(seen[0]), 1);
            check("rr_g1", int'(seen[1]), 2);
            check("rr_g2", int'(seen[2]), 4);
            check("rr_g3", int'(seen[3]), 8);
            check("rr_spacing", at[3] - at[0], 6);
        end
        tick(4'b0000);
        check("rr_pend_after", int'(io.pend), 0);
        check("rr_count_after", int'($signed(io.count)), 0);

        // Inc saturation: nine incs from 0 each still granted
        ng = 0;
        for (int i = 0; i < 9; i++) begin
            tick(4'b0010);
            tick(4'b0000);
            if (io.grant == 4'b0010) ng++;
            tick(4'b0000);
        end
        check("sat_grants", ng, 9);
        check("sat_count", int'($signed(io.count)), 7);

        // Async reset in the middle of an EXEC cycle
        tick(4'b0001);
        tick(4'b0000);
        check("midexec_grant", int'(io.grant), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_count", int'($signed(io.count)), 0);
        check("async_grant", int'(io.grant), 0);
        check("async_pend", int'(io.pend), 0);
        check("async_led", int'(io.usr_led), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        tick(4'b0010);
        tick(4'b0000);
        check("post_rst_grant", int'(io.grant), 2);
        tick(4'b0000);
        check("post_rst_count", int'($signed(io.count)), 1);

        // Collision: req[0] during the EXEC of a req[0] grant
        do_reset();
        tick(4'b0001);
        tick(4'b0000);
        check("coll_grant1", int'(io.grant), 1);
        tick(4'b0001);
        check("coll_pend", int'(io.pend), 1);
        check("coll_count1", int'($signed(io.count)), -1);
        tick(4'b0000);
        check("coll_grant2", int'(io.grant), 1);
        tick(4'b0000);
        check("coll_count2", int'($signed(io.count)), -2);
        check("coll_pend_after", int'(io.pend), 0);

        // Level staging at the PWM wrap
        do_reset();
        tick(4'b0010);
        tick(4'b0000);
        tick(4'b0000);
        guard = 0;
        while (m_cnt != 10 && guard < 3 * P) begin
            tick(4'b0000);
            guard++;
        end
        check("stage_reach", (guard < 3 * P) ? 1 : 0, 1);
        tick(4'b1000);
        tick(4'b0000);
        tick(4'b1000);
        tick(4'b0000);
        tick(4'b0000);
        bad = 1'b0;
        guard = 0;
        do begin
            tick(4'b0000);
            guard++;
            if (m_cnt != 0 && io.level != 3'd0) bad = 1'b1;
        end while (m_cnt != 0 && guard < 3 * P);
        check("stage_hold", int'(bad), 0);
        check("stage_level", int'(io.level), 2);
        nz = 0;
        for (int i = 0; i < P; i++) begin
            tick(4'b0000);
            if (io.usr_led != 4'b0000) nz++;
        end
        check("stage_led_on", nz, 50);

        // Without auto-dim nothing changes the level when idle
        repeat (200) tick(4'b0000);
        check("idle_level", int'(io.level), 2);
        check("idle_pend", int'(io.pend), 0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] rq;
            for (int b = 0; b < 4; b++) rq[b] = ($urandom_range(0, 5) == 0);
            tick(rq);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
